// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its instruction sequencer.
// Instruction word layout: opcode sits directly above the N-bit operand.
package cpu_pkg;

   localparam int OPC_W   = 3;
   localparam int OPR_LSB = 0;

   typedef enum logic [OPC_W-1:0] {
      OP_LOAD = 3'b000,
      OP_ADD  = 3'b001,
      OP_MUL  = 3'b010,
      OP_SUB  = 3'b011,
      OP_AND  = 3'b100,
      OP_NOT  = 3'b101,
      OP_DIS  = 3'b110,
      OP_HLT  = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_RUN    = 2'd2,
      ST_HALTED = 2'd3
   } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Host programming/control signals and the core-facing instruction bus.
// The slave side is the sequencer; the master side is the host/core environment.
interface instr_sequencer_if #(
   parameter int N  = 5,
   parameter int AW = 4
);
   logic           prog_we;
   logic [AW-1:0]  prog_addr;
   logic [N+2:0]   prog_wdata;
   logic           run;
   logic           pause;
   logic           abort;
   logic           START;
   logic [2:0]     OPC;
   logic [N-1:0]   OPR;
   logic [AW-1:0]  pc;
   logic           busy;
   logic           done;
   logic           overrun;
   logic [AW:0]    icount;

   modport master (
      output prog_we, prog_addr, prog_wdata, run, pause, abort,
      input  START, OPC, OPR, pc, busy, done, overrun, icount
   );

   modport slave (
      input  prog_we, prog_addr, prog_wdata, run, pause, abort,
      output START, OPC, OPR, pc, busy, done, overrun, icount
   );
endinterface

// File: rtl/instr_sequencer_chk.sv
// Invariants of the sequencer outputs, for attachment in simulation.
module instr_sequencer_chk #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input logic        CLK,
   input logic        RESET,
   input logic        START,
   input logic [2:0]  OPC,
   input logic        busy,
   input logic        done,
   input logic [AW:0] icount
);

   a_start_busy: assert property (@(posedge CLK) disable iff (RESET) START == busy);
   a_done_idle:  assert property (@(posedge CLK) disable iff (RESET) done |-> !busy);
   a_stop_dis:   assert property (@(posedge CLK) disable iff (RESET) !START |-> (OPC == 3'b110));
   a_icnt_max:   assert property (@(posedge CLK) disable iff (RESET) int'(icount) <= DEPTH);

endmodule

// File: rtl/prog_mem.sv
// Program memory: synchronous write, registered read with a read enable
// so the fetched word can be held while the sequencer stalls.
module prog_mem #(
   parameter int N     = 5,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [N+2:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [N+2:0]  rdata
);

   logic [N+2:0] mem_q [DEPTH];
   logic [N+2:0] rdata_q;

   // Host write port
   always_ff @(posedge CLK) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Registered read port; holds its word when re is low
   always_ff @(posedge CLK) begin
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Feeds the accumulator core one instruction per cycle from a host-loaded program,
// with two leading bubbles, pause stalls, abort, and halt on HLT or end of memory.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int N     = 5,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input logic               CLK,
   input logic               RESET,
   instr_sequencer_if.slave  bus
);

   localparam int            OPC_LSB   = OPR_LSB + N;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PC_ONE    = AW'(1);
   localparam logic [AW:0]   ICNT_ONE  = (AW + 1)'(1);

   seq_state_e          state_q, state_d;
   logic                start_q, start_d;
   logic [OPC_W-1:0]    opc_q, opc_d;
   logic [N-1:0]        opr_q, opr_d;
   logic [AW-1:0]       pc_q, pc_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                over_q, over_d;
   logic [AW:0]         icnt_q, icnt_d;
   logic                rd_last_q, rd_last_d;   // fetched word came from LAST_ADDR
   logic                out_last_q, out_last_d; // output holds the final instruction

   logic                mem_we_s;
   logic                mem_re_s;
   logic [N+2:0]        mem_rdata_s;
   logic [OPC_W-1:0]    rd_opc_s;
   logic [N-1:0]        rd_opr_s;
   logic                rd_stop_s;
   logic [AW-1:0]       pc_inc_s;

   prog_mem #(
      .N     (N),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .CLK   (CLK),
      .we    (mem_we_s & ~RESET),
      .waddr (bus.prog_addr),
      .wdata (bus.prog_wdata),
      .re    (mem_re_s),
      .raddr (pc_q),
      .rdata (mem_rdata_s)
   );

   assign rd_opc_s  = mem_rdata_s[OPC_LSB +: OPC_W];
   assign rd_opr_s  = mem_rdata_s[OPR_LSB +: N];
   assign rd_stop_s = (rd_opc_s == OP_HLT) || rd_last_q;
   assign pc_inc_s  = (pc_q == LAST_ADDR) ? pc_q : (pc_q + PC_ONE);

   // Next-state, fetch control and next output values
   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      opc_d      = opc_q;
      opr_d      = opr_q;
      pc_d       = pc_q;
      busy_d     = busy_q;
      done_d     = done_q;
      over_d     = over_q;
      icnt_d     = icnt_q;
      rd_last_d  = rd_last_q;
      out_last_d = out_last_q;
      mem_we_s   = 1'b0;
      mem_re_s   = 1'b0;

      if (bus.abort) begin
         state_d    = ST_IDLE;
         start_d    = 1'b0;
         opc_d      = OP_DIS;
         opr_d      = {N{1'b0}};
         busy_d     = 1'b0;
         done_d     = 1'b0;
         rd_last_d  = 1'b0;
         out_last_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_HALTED: begin
               mem_we_s = bus.prog_we;
               if (bus.run) begin
                  state_d    = ST_FILL;
                  start_d    = 1'b1;
                  opc_d      = OP_DIS;
                  opr_d      = {N{1'b0}};
                  pc_d       = {AW{1'b0}};
                  busy_d     = 1'b1;
                  done_d     = 1'b0;
                  over_d     = 1'b0;
                  icnt_d     = {(AW + 1){1'b0}};
                  rd_last_d  = 1'b0;
                  out_last_d = 1'b0;
               end else begin
                  start_d = 1'b0;
                  opc_d   = OP_DIS;
                  opr_d   = {N{1'b0}};
               end
            end
            ST_FILL: begin
               // Pause is not honoured here; the first fetch always goes out
               mem_re_s  = 1'b1;
               rd_last_d = (pc_q == LAST_ADDR);
               pc_d      = pc_inc_s;
               state_d   = ST_RUN;
            end
            ST_RUN: begin
               if (out_last_q) begin
                  state_d    = ST_HALTED;
                  start_d    = 1'b0;
                  opc_d      = OP_DIS;
                  opr_d      = {N{1'b0}};
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  over_d     = (opc_q != OP_HLT);
                  out_last_d = 1'b0;
               end else if (bus.pause) begin
                  opc_d = OP_DIS;
                  opr_d = {N{1'b0}};
               end else begin
                  opc_d      = rd_opc_s;
                  opr_d      = rd_opr_s;
                  icnt_d     = icnt_q + ICNT_ONE;
                  out_last_d = rd_stop_s;
                  // Nothing past HLT or past the last address is ever fetched
                  if (rd_stop_s) begin
                     mem_re_s = 1'b0;
                  end else begin
                     mem_re_s  = 1'b1;
                     rd_last_d = (pc_q == LAST_ADDR);
                     pc_d      = pc_inc_s;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               start_d = 1'b0;
               opc_d   = OP_DIS;
               opr_d   = {N{1'b0}};
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         opc_q      <= OP_DIS;
         opr_q      <= {N{1'b0}};
         pc_q       <= {AW{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         over_q     <= 1'b0;
         icnt_q     <= {(AW + 1){1'b0}};
         rd_last_q  <= 1'b0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         opc_q      <= opc_d;
         opr_q      <= opr_d;
         pc_q       <= pc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         over_q     <= over_d;
         icnt_q     <= icnt_d;
         rd_last_q  <= rd_last_d;
         out_last_q <= out_last_d;
      end
   end

   assign bus.START   = start_q;
   assign bus.OPC     = opc_q;
   assign bus.OPR     = opr_q;
   assign bus.pc      = pc_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.overrun = over_q;
   assign bus.icount  = icnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program scenarios plus randomized control
// traffic, checked every cycle against a transaction-level model of the sequencer.
module tb_instr_sequencer;

   localparam int N     = 5;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   instr_sequencer_if #(.N(N), .AW(AW)) bus ();

   instr_sequencer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   instr_sequencer_chk #(.DEPTH(DEPTH), .AW(AW)) u_chk (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (bus.START),
      .OPC    (bus.OPC),
      .busy   (bus.busy),
      .done   (bus.done),
      .icount (bus.icount)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: mode 0 idle, 1 running, 2 halted
   logic [N+2:0] m_mem [DEPTH];
   int m_mode = 0, m_warm = 0, m_next = 0, m_fetched = 0, m_last_opc = 0;
   bit m_final = 1'b0;
   int e_start = 0, e_opc = 6, e_opr = 0, e_pc = 0, e_busy = 0, e_done = 0, e_over = 0, e_icnt = 0;
   int cap_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [N+2:0] word;
      if (RESET) begin
         m_mode = 0; e_start = 0; e_opc = 6; e_opr = 0; e_pc = 0;
         e_busy = 0; e_done = 0; e_over = 0; e_icnt = 0;
      end else if (bus.abort) begin
         m_mode = 0; e_start = 0; e_opc = 6; e_opr = 0; e_busy = 0; e_done = 0;
      end else if (m_mode != 1) begin
         if (bus.prog_we) m_mem[bus.prog_addr] = bus.prog_wdata;
         if (bus.run) begin
            m_mode = 1; m_warm = 1; m_next = 0; m_fetched = 0; m_final = 1'b0;
            e_start = 1; e_opc = 6; e_opr = 0; e_pc = 0; e_icnt = 0;
            e_busy = 1; e_done = 0; e_over = 0;
         end
      end else if (m_warm > 0) begin
         m_warm = 0; m_fetched = 1; e_pc = 1;
      end else if (m_final) begin
         m_mode = 2; e_start = 0; e_opc = 6; e_opr = 0; e_busy = 0; e_done = 1;
         e_over = (m_last_opc != 7) ? 1 : 0;
      end else if (bus.pause) begin
         e_opc = 6; e_opr = 0;
      end else begin
         word = m_mem[m_next];
         e_opc = int'(word[N+2:N]);
         e_opr = int'(word[N-1:0]);
         e_icnt++;
         m_last_opc = e_opc;
         m_final = (e_opc == 7) || (m_next == DEPTH - 1);
         m_next++;
         if (!m_final) m_fetched = (m_fetched + 1 > DEPTH) ? DEPTH : m_fetched + 1;
         e_pc = (m_fetched > DEPTH - 1) ? DEPTH - 1 : m_fetched;
      end
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("START", bus.START, e_start);
         chk("OPC", bus.OPC, e_opc);
         chk("OPR", bus.OPR, e_opr);
         chk("pc", bus.pc, e_pc);
         chk("busy", bus.busy, e_busy);
         chk("done", bus.done, e_done);
         chk("overrun", bus.overrun, e_over);
         chk("icount", bus.icount, e_icnt);
      end
   end

   task automatic cyc(input logic we, input logic [AW-1:0] addr, input logic [N+2:0] data,
                      input logic run, input logic pause, input logic abort, input logic rst);
      bus.prog_we = we; bus.prog_addr = addr; bus.prog_wdata = data;
      bus.run = run; bus.pause = pause; bus.abort = abort; RESET = rst;
      @(posedge CLK);
      #1;
      model_step();
   endtask

   task automatic idle();
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load(input int addr, input int opc, input int opr);
      cyc(1'b1, AW'(addr), (N+3)'((opc << N) | opr), 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load_base();
      for (int i = 0; i < DEPTH; i++) load(i, 0, 0);
      load(0, 0, 3); load(1, 1, 4); load(2, 2, 2); load(3, 6, 0); load(4, 7, 0);
   endtask

   task automatic run_capture(input int max);
      cap_q.delete();
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.START) cap_q.push_back(int'(bus.OPC) * 256 + int'(bus.OPR));
      for (int i = 0; i < max && !bus.done; i++) begin
         idle();
         if (bus.START) cap_q.push_back(int'(bus.OPC) * 256 + int'(bus.OPR));
      end
      chk("done_seen", bus.done, 1);
   endtask

   function automatic int core_apply(input int acc, input int opc, input int opr);
      case (opc)
         0: return opr;
         1: return (acc + opr) & 255;
         2: return (acc * opr) & 255;
         3: return (acc - opr) & 255;
         4: return acc & opr;
         5: return (~acc) & 255;
         default: return acc;
      endcase
   endfunction

   initial begin : stim
      int exp_opc [5] = '{0, 1, 2, 6, 7};
      int exp_opr [5] = '{3, 4, 2, 0, 0};
      int acc;
      int n_add;

      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_en = 1'b1;
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_OPC", bus.OPC, 6);
      chk("rst_START", bus.START, 0);
      load_base();

      // Basic run
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("b0_START", bus.START, 1);
      chk("b0_OPC", bus.OPC, 6);
      idle();
      chk("b1_OPC", bus.OPC, 6);
      chk("b1_pc", bus.pc, 1);
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         idle();
         chk("seq_OPC", bus.OPC, exp_opc[k]);
         chk("seq_START", bus.START, 1);
         if (k < 3) chk("seq_OPR", bus.OPR, exp_opr[k]);
         if (bus.OPC == 3'b111) chk("acc_before_hlt", acc, 14);
         acc = core_apply(acc, int'(bus.OPC), int'(bus.OPR));
      end
      idle();
      chk("end_START", bus.START, 0);
      chk("end_done", bus.done, 1);
      chk("end_icount", bus.icount, 5);
      chk("end_overrun", bus.overrun, 0);

      // Pause for three cycles after ADD
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(); idle(); idle();
      chk("p_add", bus.OPC, 1);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
         chk("p_bubble", bus.OPC, 6);
         chk("p_START", bus.START, 1);
      end
      idle();
      chk("p_mul_opc", bus.OPC, 2);
      chk("p_mul_opr", bus.OPR, 2);
      for (int i = 0; i < 10 && !bus.done; i++) idle();
      chk("p_icount", bus.icount, 5);

      // End of memory without HLT
      for (int i = 0; i < DEPTH; i++) load(i, 1, 1);
      run_capture(40);
      n_add = 0;
      foreach (cap_q[i]) if (cap_q[i] == 256 + 1) n_add++;
      chk("ovr_adds", n_add, 16);
      chk("ovr_len", cap_q.size(), 18);
      chk("ovr_flag", bus.overrun, 1);
      chk("ovr_icount", bus.icount, 16);
      chk("ovr_pc", bus.pc, 15);

      // Abort just after issuing begins, then rerun
      load_base();
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(); idle();
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ab_START", bus.START, 0);
      chk("ab_OPC", bus.OPC, 6);
      chk("ab_busy", bus.busy, 0);
      chk("ab_icount", bus.icount, 1);
      run_capture(40);
      chk("ab_first", cap_q[2], 3);
      chk("ab_len", cap_q.size(), 7);

      // Write during run is ignored
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      load(0, 1, 9);
      for (int i = 0; i < 10 && !bus.done; i++) idle();
      run_capture(40);
      chk("we_first", cap_q[2], 3);

      // Reset mid-run, then replay
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(); idle(); idle();
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("mr_START", bus.START, 0);
      chk("mr_OPC", bus.OPC, 6);
      chk("mr_pc", bus.pc, 0);
      chk("mr_icount", bus.icount, 0);
      run_capture(40);
      chk("mr_len", cap_q.size(), 7);
      chk("mr_last", cap_q[6], 7 * 256);
      chk("mr_icount2", bus.icount, 5);

      // Random control traffic
      for (int c = 0; c < 3000; c++) begin
         cyc(($urandom % 3) == 0, AW'($urandom), (N+3)'($urandom), ($urandom % 8) == 0,
             ($urandom % 4) == 0, ($urandom % 60) == 0, ($urandom % 250) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
